// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - register file write-port arbiter for WB and multi-cycle results
// MC results queue in a FIFO; a starvation counter forces a WB stall so they drain.
module regfile_write_scheduler #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 wb_stall,
  input  logic                 mc_valid,
  input  logic [ADDR_W-1:0]    mc_reg,
  input  logic [DATA_W-1:0]    mc_data,
  output logic                 mc_ready,
  output logic [ADDR_W-1:0]    write_register,
  output logic [DATA_W-1:0]    write_data,
  output logic                 write_enable,
  output logic [2**ADDR_W-1:0] pending_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_reg_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              src_mc_q;
  logic [ADDR_W-1:0] write_register_q;
  logic [DATA_W-1:0] write_data_q;
  logic              write_enable_q;

  logic fifo_empty, fifo_full, starved, mc_win, wb_win, push;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign starved    = (starve_q == ST_W'(STARVE_LIMIT));
  assign head_reg   = fifo_reg_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign mc_win   = !rst && !fifo_empty && (!wb_valid || starved);
  assign wb_win   = !rst && wb_valid && !mc_win;
  // Fullness alone gates acceptance; a same-cycle pop does not free a slot early.
  assign push     = !rst && mc_valid && !fifo_full;
  assign mc_ready = !rst && !fifo_full;
  assign wb_stall = wb_valid && mc_win;

  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign write_enable   = write_enable_q;

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(mc_win);
    starve_d = starve_q;
    if (fifo_empty || mc_win) begin
      starve_d = '0;
    end else if (wb_win && !starved) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) begin
        pending_mask[fifo_reg_q[i]] = 1'b1;
      end
    end
    if (write_enable_q && src_mc_q) begin
      pending_mask[write_register_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= mc_reg;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      starve_q         <= '0;
      src_mc_q         <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      write_enable_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (mc_win) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q  <= count_d;
      starve_q <= starve_d;
      // Register 0 writes still win arbitration but are never issued.
      if (mc_win) begin
        write_register_q <= head_reg;
        write_data_q     <= head_data;
        write_enable_q   <= (head_reg != '0);
        src_mc_q         <= 1'b1;
      end else if (wb_win) begin
        write_register_q <= wb_reg;
        write_data_q     <= wb_data;
        write_enable_q   <= (wb_reg != '0);
        src_mc_q         <= 1'b0;
      end else begin
        write_enable_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - scoreboard bench for regfile_write_scheduler
// A queue-based reference model predicts issued writes; a monitor pops and compares them.
module tb_regfile_write_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FD = 2;
  localparam int SL = 4;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          mc_valid;
  logic [AW-1:0] mc_reg;
  logic [DW-1:0] mc_data;
  logic          mc_ready;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [31:0]   pending_mask;

  regfile_write_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .write_register(write_register), .write_data(write_data),
    .write_enable(write_enable), .pending_mask(pending_mask)
  );

  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  typedef struct { int c; logic [AW-1:0] r; logic [DW-1:0] d; } wr_t;

  ent_t mq[$];
  wr_t  exp_q[$];
  int   starve = 0;
  logic [AW-1:0] out_mc_reg = '0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: evaluates the arbitration rules on the current cycle's inputs.
  always @(negedge clk) begin
    logic [31:0] m;
    logic ready_e, mc_w, wb_w;
    ent_t e;
    m = '0;
    foreach (mq[k]) m[mq[k].r] = 1'b1;
    if (out_mc_reg != 0) m[out_mc_reg] = 1'b1;
    m[0] = 1'b0;
    ready_e = !rst && (mq.size() < FD);
    mc_w = !rst && (mq.size() > 0) && (!wb_valid || starve == SL);
    wb_w = !rst && wb_valid && !mc_w;
    chk("mc_ready", mc_ready, ready_e);
    chk("wb_stall", wb_stall, wb_valid && mc_w);
    chk("pending_mask", pending_mask, m);
    if (rst) begin
      mq.delete();
      starve = 0;
      out_mc_reg = '0;
    end else begin
      if (mc_w) begin
        e = mq.pop_front();
        if (e.r != 0) exp_q.push_back('{cyc + 1, e.r, e.d});
        out_mc_reg = e.r;
        starve = 0;
      end else begin
        out_mc_reg = '0;
        if (wb_w && wb_reg != 0) exp_q.push_back('{cyc + 1, wb_reg, wb_data});
        if (mq.size() == 0) starve = 0;
        else if (wb_w && starve < SL) starve++;
      end
      if (mc_valid && ready_e) mq.push_back('{mc_reg, mc_data});
    end
  end

  // Monitor: every issued write must match the oldest prediction for this cycle.
  always @(negedge clk) begin
    wr_t w;
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      w = exp_q.pop_front();
      chk("late_write", 0, 1);
    end
    if (write_enable) begin
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        w = exp_q.pop_front();
        chk("write_register", write_register, w.r);
        chk("write_data", write_data, w.d);
      end else begin
        chk("spurious_write", write_enable, 0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      w = exp_q.pop_front();
      chk("missing_write", write_enable, 1);
    end
  end

  task automatic step(input logic r, input logic wv, input logic [AW-1:0] wr,
                      input logic [DW-1:0] wd, input logic mv,
                      input logic [AW-1:0] mr, input logic [DW-1:0] md);
    @(posedge clk);
    #1;
    rst = r; wb_valid = wv; wb_reg = wr; wb_data = wd;
    mc_valid = mv; mc_reg = mr; mc_data = md;
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    int stall_at, pop_at, ready_at;
    rst = 1'b1; wb_valid = 0; wb_reg = '0; wb_data = '0;
    mc_valid = 0; mc_reg = '0; mc_data = '0;

    step(1, 0, '0, '0, 0, '0, '0);
    step(1, 0, '0, '0, 0, '0, '0);
    idle();
    chk("rst_we", write_enable, 0);
    chk("rst_wreg", write_register, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_ready", mc_ready, 1);
    chk("rst_mask", pending_mask, 0);

    step(0, 1, 5'd3, 32'hDEADBEEF, 0, '0, '0);
    chk("wb_only_stall", wb_stall, 0);
    idle();
    chk("wb_only_we", write_enable, 1);
    chk("wb_only_reg", write_register, 3);
    chk("wb_only_data", write_data, 32'hDEADBEEF);

    step(0, 0, '0, '0, 1, 5'd7, 32'h12345678);
    idle();
    chk("mc_mask_n1", pending_mask[7], 1);
    idle();
    chk("mc_we_n2", write_enable, 1);
    chk("mc_reg_n2", write_register, 7);
    chk("mc_mask_n2", pending_mask[7], 1);
    idle();
    chk("mc_mask_n3", pending_mask, 0);

    step(0, 1, 5'd5, 32'h55, 1, 5'd9, 32'h99);
    stall_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 5'd5, $urandom, 0, '0, '0);
      if (wb_stall) begin
        stall_at = i;
        break;
      end
    end
    chk("starve_wb_wins", stall_at, SL);
    step(0, 1, 5'd5, 32'h56, 0, '0, '0);
    chk("starve_resume", wb_stall, 0);
    chk("starve_mc_we", write_enable, 1);
    chk("starve_mc_reg", write_register, 9);
    idle();

    step(0, 1, 5'd8, 32'h1, 1, 5'd10, 32'hA);
    step(0, 1, 5'd8, 32'h2, 1, 5'd11, 32'hB);
    pop_at = -1;
    ready_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 5'd8, $urandom, 1, 5'd12, 32'hC);
      if (i == 0) chk("full_ready", mc_ready, 0);
      if (wb_stall) pop_at = i;
      if (mc_ready) begin
        ready_at = i;
        break;
      end
    end
    chk("full_pop_at", pop_at, SL - 1);
    chk("full_ready_at", ready_at, SL);
    for (int i = 0; i < 4; i++) idle();

    step(0, 1, 5'd0, 32'hFFFF, 0, '0, '0);
    chk("r0_stall", wb_stall, 0);
    idle();
    chk("r0_we", write_enable, 0);

    step(0, 1, 5'd6, 32'h66, 1, 5'd13, 32'hD);
    step(0, 1, 5'd6, 32'h67, 1, 5'd14, 32'hE);
    step(1, 1, 5'd6, 32'h68, 1, 5'd15, 32'hF);
    chk("rst_mid_ready", mc_ready, 0);
    chk("rst_mid_stall", wb_stall, 0);
    chk("rst_mid_mask_pre", pending_mask, (32'h1 << 13) | (32'h1 << 14));
    idle();
    chk("rst_mid_mask", pending_mask, 0);
    chk("rst_mid_ready_after", mc_ready, 1);
    chk("rst_mid_we", write_enable, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_mid_no_write", write_enable, 0);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
           AW'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 31)), $urandom);
    end
    for (int i = 0; i < 6; i++) idle();
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
